fifo_word_packer: RTL
=====================

# fifo_word_packer

Read-side companion to the generic FIFO: pops narrow words from a FIFO head, packs `PACK_RATIO` consecutive words into one wide beat, and presents that beat on a valid/ready stream to the downstream accelerator datapath. A flush request closes a partially filled beat early, marking it last and reporting how many lanes are valid.

## Interface
- `DATA_WIDTH`, 8, width of one FIFO word.
- `PACK_RATIO`, 4, words per output beat (≥2). Output width is `DATA_WIDTH*PACK_RATIO`; count width `CW = $clog2(PACK_RATIO+1)`.

- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_data_out`  in  DATA_WIDTH  FIFO head word, shown combinationally while FIFO non-empty.
- `fifo_data_out_vld`  in  1  FIFO non-empty.
- `fifo_data_pop`  out  DATA_WIDTH-independent 1  pop strobe; head word consumed at this edge.
- `flush`  in  1  request to close the current beat early (single-cycle pulse is sufficient).
- `pk_data`  out  DATA_WIDTH*PACK_RATIO  packed beat; lane 0 (LSBs) = oldest word.
- `pk_count`  out  CW  number of valid lanes in `pk_data` (1..PACK_RATIO).
- `pk_last`  out  1  beat was closed by a flush.
- `pk_vld`  out  1  beat valid.
- `pk_rdy`  in  1  downstream accepts beat.
- `busy`  out  1  accumulator non-empty, beat held, or flush pending.

## Operation
- States: FILL (accumulate), HOLD (beat presented). Internal lane counter `cnt` (0..PACK_RATIO-1), sticky `flush_pend`.
- `fifo_data_pop = (state==FILL) & fifo_data_out_vld & !reset` (combinational).
- FILL, on pop: `fifo_data_out` written into lane `cnt`; `cnt` increments.
- FILL → HOLD when pop occurs with `cnt==PACK_RATIO-1`: `pk_count=PACK_RATIO`, `pk_last=flush_eff`, `cnt` wraps to 0.
- `flush_eff = flush | flush_pend`. `flush` in any state sets `flush_pend`; it is acted on only in FILL:
  - words this beat (`cnt` + pop this cycle) > 0 → go HOLD, `pk_count` = that total, `pk_last=1`, clear `flush_pend`.
  - total = 0 → clear `flush_pend`, no beat emitted.
- The word popped in the flush cycle is included in the closed beat.
- HOLD: `pk_vld=1`; `pk_data/pk_count/pk_last` stable until `pk_vld & pk_rdy`. No pops in HOLD.
- Handshake in HOLD → FILL next cycle; all lanes cleared to 0, `cnt=0`, `pk_last=0`. Unused lanes of a partial beat read 0.
- Flush arriving during HOLD is not applied to the held beat; it stays pending and is resolved in the first FILL cycle (usually producing no beat, or a 1-word last beat if the FIFO has data that cycle).
- `busy = (cnt!=0) | (state==HOLD) | flush_pend`.

## Timing
- Reset (synchronous, edge with `reset=1`): state FILL, `cnt=0`, `flush_pend=0`, `pk_data=0`, `pk_count=0`, `pk_last=0`, `pk_vld=0`, `busy=0`; `fifo_data_pop=0` while `reset` high. Reset in HOLD discards the beat; the next word lands in lane 0.
- Pop latency: FIFO non-empty in FILL → `fifo_data_pop` same cycle, word captured at that edge.
- Beat latency: `pk_vld` high in the cycle after the edge capturing the final word (or the flush edge).
- Throughput with `pk_rdy=1` and FIFO never empty: one beat per `PACK_RATIO+1` cycles (one HOLD cycle per beat, no bypass).
- `pk_vld` never drops without a handshake except on reset.

## Test plan
- DW=8, PR=4; push 0x11,0x22,0x33,0x44, `pk_rdy=1` → four consecutive pops, then `pk_data=0x44332211`, `pk_count=4`, `pk_last=0`, `pk_vld` high exactly one cycle.
- 8 words 0x11..0x88 queued, `pk_rdy=0` for 5 cycles after first `pk_vld` → `fifo_data_pop` stays 0, `pk_data` stable at 0x44332211; after release, second beat 0x88776655.
- Words 0xA1,0xA2, FIFO then empty, pulse `flush` → `pk_data=0x0000A2A1`, `pk_count=2`, `pk_last=1`; `busy` low after handshake.
- `flush` coincident with 4th pop (0x01..0x04) → `pk_data=0x04030201`, `pk_count=4`, `pk_last=1`.
- `flush` with `cnt=0` and FIFO empty → no `pk_vld`; `busy` high one cycle, then low. `flush` during HOLD with FIFO empty → held beat unchanged (`pk_last=0`), no extra beat.
- `reset` asserted for one cycle while HOLD holds 0x44332211 → `pk_vld=0` and all outputs 0 next cycle; next words 0x55.. start at lane 0.

Source files
------------

// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between the FIFO head, the word packer and the downstream
// wide-beat consumer.
interface fifo_word_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
);
    localparam int CW = $clog2(PACK_RATIO + 1);

    logic [DATA_WIDTH-1:0]            fifo_data_out;
    logic                             fifo_data_out_vld;
    logic                             fifo_data_pop;
    logic                             flush;
    logic [DATA_WIDTH*PACK_RATIO-1:0] pk_data;
    logic [CW-1:0]                    pk_count;
    logic                             pk_last;
    logic                             pk_vld;
    logic                             pk_rdy;
    logic                             busy;

    modport master (
        input  fifo_data_out, fifo_data_out_vld, flush, pk_rdy,
        output fifo_data_pop, pk_data, pk_count, pk_last, pk_vld, busy
    );

    modport slave (
        output fifo_data_out, fifo_data_out_vld, flush, pk_rdy,
        input  fifo_data_pop, pk_data, pk_count, pk_last, pk_vld, busy
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops narrow FIFO words, packs PACK_RATIO of them (lane 0 = oldest) into one
// wide beat and holds it on a valid/ready stream; flush closes a partial beat.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_word_packer_if.master   pk
);
    localparam int CW   = $clog2(PACK_RATIO + 1);
    localparam int CNTW = $clog2(PACK_RATIO);
    localparam int BW   = DATA_WIDTH * PACK_RATIO;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_r, state_n;
    logic [CNTW-1:0] cnt_r, cnt_n;
    logic            flush_pend_r, flush_pend_n;
    logic [BW-1:0]   data_r, data_n;
    logic [CW-1:0]   count_r, count_n;
    logic            last_r, last_n;

    logic            pop_s;
    logic            flush_eff_s;
    logic [CW-1:0]   total_s;

    assign pop_s       = (state_r == FILL) & pk.fifo_data_out_vld & ~reset;
    assign flush_eff_s = pk.flush | flush_pend_r;
    assign total_s     = CW'(cnt_r) + CW'(pop_s);

    // State and beat registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FILL;
            cnt_r        <= '0;
            flush_pend_r <= 1'b0;
            data_r       <= '0;
            count_r      <= '0;
            last_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            flush_pend_r <= flush_pend_n;
            data_r       <= data_n;
            count_r      <= count_n;
            last_r       <= last_n;
        end
    end

    // Next-state, lane write and flush resolution.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        flush_pend_n = flush_pend_r | pk.flush;
        data_n       = data_r;
        count_n      = count_r;
        last_n       = last_r;
        case (state_r)
            FILL: begin
                if (pop_s) begin
                    data_n[cnt_r*DATA_WIDTH +: DATA_WIDTH] = pk.fifo_data_out;
                end else begin
                    data_n = data_r;
                end
                if (pop_s && (cnt_r == CNTW'(PACK_RATIO - 1))) begin
                    state_n      = HOLD;
                    cnt_n        = '0;
                    count_n      = CW'(PACK_RATIO);
                    last_n       = flush_eff_s;
                    flush_pend_n = 1'b0;
                end else if (flush_eff_s) begin
                    if (total_s != CW'(0)) begin
                        state_n      = HOLD;
                        cnt_n        = '0;
                        count_n      = total_s;
                        last_n       = 1'b1;
                        flush_pend_n = 1'b0;
                    end else begin
                        // A fresh flush with nothing to close lingers one
                        // cycle (visible on busy); an old pending one retires.
                        flush_pend_n = ~flush_pend_r;
                    end
                end else if (pop_s) begin
                    cnt_n = cnt_r + CNTW'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
            HOLD: begin
                if (pk.pk_rdy) begin
                    state_n = FILL;
                    cnt_n   = '0;
                    data_n  = '0;
                    count_n = '0;
                    last_n  = 1'b0;
                end else begin
                    state_n = HOLD;
                end
            end
            default: begin
                state_n      = FILL;
                cnt_n        = '0;
                flush_pend_n = 1'b0;
                data_n       = '0;
                count_n      = '0;
                last_n       = 1'b0;
            end
        endcase
    end

    assign pk.fifo_data_pop = pop_s;
    assign pk.pk_data       = data_r;
    assign pk.pk_count      = count_r;
    assign pk.pk_last       = last_r;
    assign pk.pk_vld        = (state_r == HOLD);
    assign pk.busy          = (cnt_r != '0) | (state_r == HOLD) | flush_pend_r;

endmodule
